data_memory_rv32: RTL and testbench

//  Byte-addressed RV32IM data memory for the MA stage. Supports LB/LH/LW/LBU/LHU and SB/SH/SW,

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_lane_align.sv | 29 ++
 rtl/data_memory_rv32.sv | 125 ++++++++++++
 tb/tb_data_memory_rv32.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 codes, FSM states and misalign check shared by data_memory_rv32.
package dmem_pkg;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

   // Stores use {1'b0, write[1:0]}, so one decoder serves both directions; reserved codes act as words.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic half;
      logic word;
      half = (f3 == F3_LH) || (f3 == F3_LHU);
      word = !half && (f3 != F3_LB) && (f3 != F3_LBU);
      return (half && a[0]) || (word && (a != 2'b00));
   endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: load lane extraction/extension and store byte-enable/lane replication.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  f3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_rep
);
   logic is_byte;
   logic is_half;
   logic is_uns;
   logic [7:0] b;
   logic [15:0] h;

   always_comb begin
      is_byte = (f3 == F3_LB) || (f3 == F3_LBU);
      is_half = (f3 == F3_LH) || (f3 == F3_LHU);
      is_uns = (f3 == F3_LBU) || (f3 == F3_LHU);
      b = rword[{addr_lo, 3'b000} +: 8];
      h = addr_lo[1] ? rword[31:16] : rword[15:0];
      load_data = is_byte ? {{24{b[7] & ~is_uns}}, b} : is_half ? {{16{h[15] & ~is_uns}}, h} : rword;
      byte_en = is_byte ? 4'b0001 << addr_lo : is_half ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata_rep = is_byte ? {4{wdata[7:0]}} : is_half ? {2{wdata[15:0]}} : wdata;
   end
endmodule

// File: rtl/data_memory_rv32.sv
// data_memory_rv32: byte-addressed RV32 data memory with busywait handshake and fixed access latency.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of force-aligning them.
module data_memory_rv32
   import dmem_pkg::*;
#(
   parameter int DEPTH_BYTES   = 1024,
   parameter int ADDR_W        = $clog2(DEPTH_BYTES),
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_LATENCY = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  read,
   input  logic [2:0]  write,
   input  logic [31:0] address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        busywait,
   output logic        misalign_fault,
   output logic [31:0] DEBUG_DATA,
   output logic        DEBUG_READ_ACC,
   output logic        DEBUG_WRITE_ACC
);
   localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W = $clog2(LAT_MAX) + 1;
   localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WRITE_LATENCY - 1);

   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic ld_q, ld_d;
   logic [2:0] f3_q, f3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] readdata_q, readdata_d;
   logic fault_q, fault_d;
   logic racc_q, racc_d;
   logic wacc_q, wacc_d;
   logic [7:0] mem_q [DEPTH_BYTES];
   logic req, fire, mis, we;
   logic [ADDR_W-3:0] wi;
   logic [31:0] rword, load_data, wdata_rep;
   logic [3:0] byte_en;
   logic unused_addr;

   assign unused_addr = ^address[31:ADDR_W];

`ifdef DMEM_MISALIGN_TRAP_EN
   assign mis = misaligned(f3_q, addr_q[1:0]);
`else
   assign mis = 1'b0;
`endif

   dmem_lane_align u_lane (
      .f3        (f3_q),
      .addr_lo   (addr_q[1:0]),
      .rword     (rword),
      .wdata     (wdata_q),
      .load_data (load_data),
      .byte_en   (byte_en),
      .wdata_rep (wdata_rep)
   );

   always_comb begin
      req = read[3] ^ write[2];
      fire = (state_q == ST_BUSY) && (cnt_q == '0);
      we = fire && !ld_q && !mis;
      wi = addr_q[ADDR_W-1:2];
      rword = {mem_q[{wi, 2'b11}], mem_q[{wi, 2'b10}], mem_q[{wi, 2'b01}], mem_q[{wi, 2'b00}]};
      state_d = state_q;
      cnt_d = cnt_q;
      ld_d = ld_q;
      f3_d = f3_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      if (state_q == ST_IDLE && req) begin
         state_d = ST_BUSY;
         ld_d = read[3];
         f3_d = read[3] ? read[2:0] : {1'b0, write[1:0]};
         addr_d = address[ADDR_W-1:0];
         wdata_d = writedata;
         cnt_d = read[3] ? RD_INIT : WR_INIT;
      end else if (state_q == ST_BUSY) begin
         cnt_d = cnt_q - 1'b1;
         state_d = fire ? ST_DONE : ST_BUSY;
      end else if (state_q == ST_DONE) begin
         state_d = ST_IDLE;
      end
      readdata_d = (fire && ld_q) ? (mis ? '0 : load_data) : readdata_q;
      fault_d = fire && mis;
      racc_d = fire && ld_q && !mis;
      wacc_d = we;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q <= '0;
         readdata_q <= '0;
         fault_q <= 1'b0;
         racc_q <= 1'b0;
         wacc_q <= 1'b0;
         for (int i = 0; i < DEPTH_BYTES; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         ld_q <= ld_d;
         f3_q <= f3_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         readdata_q <= readdata_d;
         fault_q <= fault_d;
         racc_q <= racc_d;
         wacc_q <= wacc_d;
         for (int i = 0; i < 4; i++) if (we && byte_en[i]) mem_q[{wi, 2'(i)}] <= wdata_rep[8*i +: 8];
      end
   end

   assign busywait = req && (state_q != ST_DONE);
   assign readdata = readdata_q;
   assign misalign_fault = fault_q;
   assign DEBUG_READ_ACC = racc_q;
   assign DEBUG_WRITE_ACC = wacc_q;
   assign DEBUG_DATA = {mem_q[ADDR_W'(3)], mem_q[ADDR_W'(2)], mem_q[ADDR_W'(1)], mem_q[ADDR_W'(0)]};
endmodule

// File: tb/tb_data_memory_rv32.sv
// tb_data_memory_rv32: random + directed accesses checked every cycle against a byte-array model.
module tb_data_memory_rv32;
   localparam int DEPTH = 1024;
   localparam int RL = 2;
   localparam int WL = 3;

   logic clock = 1'b0;
   logic reset;
   logic [3:0] read;
   logic [2:0] write;
   logic [31:0] address, writedata;
   logic [31:0] readdata, DEBUG_DATA;
   logic busywait, misalign_fault, DEBUG_READ_ACC, DEBUG_WRITE_ACC;

   always #5 clock = ~clock;

   data_memory_rv32 #(
      .DEPTH_BYTES   (DEPTH),
      .READ_LATENCY  (RL),
      .WRITE_LATENCY (WL)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .read            (read),
      .write           (write),
      .address         (address),
      .writedata       (writedata),
      .readdata        (readdata),
      .busywait        (busywait),
      .misalign_fault  (misalign_fault),
      .DEBUG_DATA      (DEBUG_DATA),
      .DEBUG_READ_ACC  (DEBUG_READ_ACC),
      .DEBUG_WRITE_ACC (DEBUG_WRITE_ACC)
   );

   int total = 0;
   int bad = 0;
   logic [7:0] mm [DEPTH];
   logic chk_en = 1'b0;
   logic exp_bw = 1'b0, exp_mf = 1'b0, exp_racc = 1'b0, exp_wacc = 1'b0;
   logic [31:0] exp_rd = '0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
      return (int'(a % 4) % nbytes(f3)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int eff(input logic [2:0] f3, input logic [31:0] a);
      int x = int'(a % DEPTH);
      return x - (x % nbytes(f3));
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
      int n = nbytes(f3);
      int x = (n == 1) ? int'(a % DEPTH) : eff(f3, a);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v |= 32'(mm[(x + i) % DEPTH]) << (8 * i);
      if (!f3[2] && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
      return v;
   endfunction

   task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      int n = nbytes(f3);
      int x = (n == 1) ? int'(a % DEPTH) : eff(f3, a);
      for (int i = 0; i < n; i++) mm[(x + i) % DEPTH] = 8'(wd >> (8 * i));
   endtask

   always @(negedge clock) if (chk_en) begin
      chk("busywait", 32'(busywait), 32'(exp_bw));
      chk("readdata", readdata, exp_rd);
      chk("misalign_fault", 32'(misalign_fault), 32'(exp_mf));
      chk("read_acc", 32'(DEBUG_READ_ACC), 32'(exp_racc));
      chk("write_acc", 32'(DEBUG_WRITE_ACC), 32'(exp_wacc));
      chk("debug_data", DEBUG_DATA, {mm[3], mm[2], mm[1], mm[0]});
   end

   task automatic access(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] got);
      int lat = ld ? RL : WL;
      logic m = model_mis(f3, a);
      @(posedge clock); #1;
      read = ld ? {1'b1, f3} : 4'b0000;
      write = ld ? 3'b000 : {1'b1, f3[1:0]};
      address = a;
      writedata = wd;
      exp_bw = 1'b1;
      exp_mf = 1'b0;
      exp_racc = 1'b0;
      exp_wacc = 1'b0;
      repeat (lat) begin
         @(posedge clock); #1;
         address = $urandom;
         writedata = $urandom;
      end
      @(posedge clock); #1;
      exp_bw = 1'b0;
      exp_mf = m;
      exp_racc = ld && !m;
      exp_wacc = !ld && !m;
      if (ld) exp_rd = m ? 32'h0 : model_load(f3, a);
      else if (!m) model_store(f3, a, wd);
      @(negedge clock);
      got = readdata;
      #1;
      read = 4'b0000;
      write = 3'b000;
      @(posedge clock); #1;
      exp_mf = 1'b0;
      exp_racc = 1'b0;
      exp_wacc = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      chk_en = 1'b0;
      read = 4'b0000;
      write = 3'b000;
      @(posedge clock); #1;
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
      exp_rd = '0;
      exp_bw = 1'b0;
      exp_mf = 1'b0;
      exp_racc = 1'b0;
      exp_wacc = 1'b0;
      chk_en = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] g;
      address = '0;
      writedata = '0;
      do_reset();
      @(negedge clock);
      chk("reset_debug", DEBUG_DATA, 32'h0);
      chk("reset_readdata", readdata, 32'h0);
      access(1'b1, 3'b010, 32'h10, 0, g);
      chk("lw10_after_reset", g, 32'h0);

      access(1'b0, 3'b010, 32'h20, 32'hDEAD_BEEF, g);
      access(1'b1, 3'b010, 32'h20, 0, g);
      chk("lw20", g, 32'hDEAD_BEEF);
      access(1'b1, 3'b000, 32'h23, 0, g);
      chk("lb23", g, 32'hFFFF_FFDE);
      access(1'b1, 3'b100, 32'h23, 0, g);
      chk("lbu23", g, 32'h0000_00DE);
      access(1'b1, 3'b001, 32'h20, 0, g);
      chk("lh20", g, 32'hFFFF_BEEF);
      access(1'b1, 3'b101, 32'h22, 0, g);
      chk("lhu22", g, 32'h0000_DEAD);
      chk("model_pin_lh20", model_load(3'b001, 32'h20), 32'hFFFF_BEEF);
      access(1'b0, 3'b000, 32'h21, 32'h0000_0055, g);
      access(1'b1, 3'b010, 32'h20, 0, g);
      chk("sb21_lw", g, 32'hDEAD_55EF);
      access(1'b0, 3'b001, 32'h22, 32'h0000_1234, g);
      access(1'b1, 3'b010, 32'h20, 0, g);
      chk("sh22_lw", g, 32'h1234_55EF);
      chk("model_pin_word", model_load(3'b010, 32'h20), 32'h1234_55EF);

      access(1'b1, 3'b010, 32'h22, 0, g);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("lw22_mis", g, 32'h0);
`else
      chk("lw22_align", g, 32'h1234_55EF);
`endif
      access(1'b1, 3'b010, 32'(DEPTH) + 32'h20, 0, g);
      chk("alias_lw", g, 32'h1234_55EF);

      access(1'b0, 3'b010, 32'h0, 32'hA5A5_5A5A, g);
      @(posedge clock); #1;
      read = 4'b1010;
      write = 3'b110;
      address = 32'h0;
      writedata = 32'hCAFE_F00D;
      repeat (4) begin @(posedge clock); #1; end
      read = 4'b0000;
      write = 3'b000;
      @(posedge clock); #1;
      chk("both_en_mem", DEBUG_DATA, 32'hA5A5_5A5A);

      @(posedge clock); #1;
      write = 3'b110;
      address = 32'h40;
      writedata = 32'h1122_3344;
      exp_bw = 1'b1;
      @(posedge clock); #1;
      do_reset();
      @(negedge clock);
      chk("abort_debug", DEBUG_DATA, 32'h0);
      access(1'b1, 3'b010, 32'h40, 0, g);
      chk("abort_lw40", g, 32'h0);

      for (int k = 0; k < 300; k++) begin
         logic [31:0] a = 32'($urandom_range(0, 63)) + 32'(DEPTH) * 32'($urandom_range(0, 3));
         access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, g);
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
